// File: rtl/seq_ssg_if.sv
// Host-side digit write bus and display pin bundle for the seven-segment scanner.
// The signal names match the driver's pin names so board-level wiring stays readable.
interface seq_ssg_if;
    logic [2:0] i_w_sel;
    logic [3:0] i_w_dig;
    logic       we;
    logic [6:0] o_w_out;
    logic [7:0] o_w_sel;

    modport master (
        output i_w_sel,
        output i_w_dig,
        output we,
        input  o_w_out,
        input  o_w_sel
    );

    modport slave (
        input  i_w_sel,
        input  i_w_dig,
        input  we,
        output o_w_out,
        output o_w_sel
    );
endinterface

// File: rtl/seq_ssg.sv
// Eight-digit common-anode seven-segment scanner with an internal hex digit store.
// Each digit stays selected for SCAN_DIV cycles; segment and enable outputs are registered.
module seq_ssg #(
    parameter int unsigned SCAN_DIV = 16
) (
    input  logic       i_w_clk,
    input  logic       i_w_reset,
    seq_ssg_if.slave   bus
);
    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);

    // Active-low segment pattern for one hex digit, bit0=a .. bit6=g.
    function automatic logic [6:0] seg_decode(input logic [3:0] hex);
        logic [6:0] pat;
        case (hex)
            4'h0:    pat = 7'h40;
            4'h1:    pat = 7'h79;
            4'h2:    pat = 7'h24;
            4'h3:    pat = 7'h30;
            4'h4:    pat = 7'h19;
            4'h5:    pat = 7'h12;
            4'h6:    pat = 7'h02;
            4'h7:    pat = 7'h78;
            4'h8:    pat = 7'h00;
            4'h9:    pat = 7'h10;
            4'hA:    pat = 7'h08;
            4'hB:    pat = 7'h03;
            4'hC:    pat = 7'h46;
            4'hD:    pat = 7'h21;
            4'hE:    pat = 7'h06;
            4'hF:    pat = 7'h0E;
            default: pat = 7'h7F;
        endcase
        return pat;
    endfunction

    logic [3:0]    digit_q [8];
    logic [3:0]    digit_d [8];
    logic [2:0]    idx_q,  idx_d;
    logic [PW-1:0] pre_q,  pre_d;
    logic [6:0]    out_q,  out_d;
    logic [7:0]    sel_q,  sel_d;

    // Digit store: host writes land on the addressed register.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            digit_d[i] = digit_q[i];
        end
        if (bus.we) begin
            digit_d[bus.i_w_sel] = bus.i_w_dig;
        end else begin
            digit_d[bus.i_w_sel] = digit_q[bus.i_w_sel];
        end
    end

    // Prescaler and scan index: advance to the next digit when the dwell time expires.
    always_comb begin
        pre_d = pre_q;
        idx_d = idx_q;
        if (pre_q == PRE_MAX) begin
            pre_d = {PW{1'b0}};
            idx_d = idx_q + 3'd1;
        end else begin
            pre_d = pre_q + {{(PW-1){1'b0}}, 1'b1};
            idx_d = idx_q;
        end
    end

    // Display drive computed from the index and digit contents held before the edge.
    always_comb begin
        sel_d = ~(8'b0000_0001 << idx_q);
        out_d = seg_decode(digit_q[idx_q]);
    end

    // State registers; reset blanks the display and overrides any concurrent write.
    always_ff @(posedge i_w_clk) begin
        if (i_w_reset) begin
            for (int i = 0; i < 8; i++) begin
                digit_q[i] <= 4'h0;
            end
            idx_q <= 3'd0;
            pre_q <= {PW{1'b0}};
            sel_q <= 8'hFF;
            out_q <= 7'h7F;
        end else begin
            for (int i = 0; i < 8; i++) begin
                digit_q[i] <= digit_d[i];
            end
            idx_q <= idx_d;
            pre_q <= pre_d;
            sel_q <= sel_d;
            out_q <= out_d;
        end
    end

    assign bus.o_w_out = out_q;
    assign bus.o_w_sel = sel_q;
endmodule

// File: tb/tb_seq_ssg.sv
// Randomized bench for seq_ssg: a default-dwell instance and a SCAN_DIV=1 instance run side by side
// against a time-based reference (shown digit = (edges since reset / dwell) mod 8).
module tb_seq_ssg;
    logic clk;
    logic rst;
    logic [2:0] sel;
    logic [3:0] dig;
    logic we;

    seq_ssg_if bus16 ();
    seq_ssg_if bus1 ();

    assign bus16.i_w_sel = sel;
    assign bus16.i_w_dig = dig;
    assign bus16.we      = we;
    assign bus1.i_w_sel  = sel;
    assign bus1.i_w_dig  = dig;
    assign bus1.we       = we;

    seq_ssg #(.SCAN_DIV(16)) dut16 (.i_w_clk(clk), .i_w_reset(rst), .bus(bus16.slave));
    seq_ssg #(.SCAN_DIV(1))  dut1  (.i_w_clk(clk), .i_w_reset(rst), .bus(bus1.slave));

    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int         div_m [2] = '{16, 1};
    int         n_m   [2];
    logic [3:0] mem_m [2][8];
    logic [7:0] exp_sel [2];
    logic [6:0] exp_out [2];

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s at %0t: got %02h expected %02h", tag, $time, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                exp_sel[k] = 8'hFF;
                exp_out[k] = 7'h7F;
                n_m[k] = 0;
                for (int d = 0; d < 8; d++) mem_m[k][d] = 4'h0;
            end else begin
                int idx;
                idx = (n_m[k] / div_m[k]) % 8;
                exp_sel[k] = ~(8'd1 << idx);
                exp_out[k] = seg_tab[mem_m[k][idx]];
                if (we) mem_m[k][sel] = dig;
                n_m[k]++;
            end
        end
        #1;
        check_eq("sel16", bus16.o_w_sel, exp_sel[0]);
        check_eq("out16", {1'b0, bus16.o_w_out}, {1'b0, exp_out[0]});
        check_eq("sel1",  bus1.o_w_sel,  exp_sel[1]);
        check_eq("out1",  {1'b0, bus1.o_w_out},  {1'b0, exp_out[1]});
    endtask

    initial begin
        int guard;
        clk = 1'b0;
        rst = 1'b1;
        we  = 1'b1;
        sel = 3'd0;
        dig = 4'h2;
        for (int k = 0; k < 2; k++) begin
            n_m[k] = 0;
            for (int d = 0; d < 8; d++) mem_m[k][d] = 4'h0;
        end
        // Reset held with a concurrent write: display blank, write dropped.
        repeat (3) step();

        rst = 1'b0; we = 1'b1; sel = 3'd0; dig = 4'h2;
        step();
        sel = 3'd1; dig = 4'h3;
        step();
        we = 1'b0; dig = 4'h4;
        repeat (40) step();

        // Walk all hex values through digit 0 while it is in view.
        rst = 1'b1; step();
        rst = 1'b0; we = 1'b1; sel = 3'd0;
        for (int v = 0; v < 16; v++) begin
            dig = 4'(v);
            step();
        end
        we = 1'b0;

        // Reset while the slow instance shows digit 5.
        guard = 0;
        while (((n_m[0] / 16) % 8) != 5 && guard < 200) begin
            step();
            guard++;
        end
        check_eq("reach_d5", 8'(guard < 200), 8'd1);
        rst = 1'b1; step();
        rst = 1'b0;
        repeat (150) step();

        for (int c = 0; c < 1500; c++) begin
            we  = (($urandom % 3) == 0);
            sel = 3'($urandom);
            dig = 4'($urandom);
            rst = (($urandom % 100) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
